// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order retirement buffer; entries are allocated at tail,
// completed by RS/LSB broadcasts and retired from head one per cycle with mispredict flush.
module reorder_buffer #(
    parameter int ROB_WIDTH = 4
) (
    input  logic                 clockIn,
    input  logic                 resetIn,
    input  logic                 readyIn,
    input  logic                 issueValid,
    input  logic [1:0]           issueType,
    input  logic [4:0]           issueRd,
    input  logic                 issuePredTaken,
    input  logic [31:0]          issueAltPc,
    output logic [ROB_WIDTH-1:0] issueRobIndex,
    output logic                 full,
    input  logic                 rsUpdate,
    input  logic [ROB_WIDTH-1:0] rsRobIndex,
    input  logic [31:0]          rsUpdateVal,
    input  logic                 lsbUpdate,
    input  logic [ROB_WIDTH-1:0] lsbRobIndex,
    input  logic [31:0]          lsbUpdateVal,
    input  logic [ROB_WIDTH-1:0] query1Index,
    output logic                 query1Ready,
    output logic [31:0]          query1Val,
    input  logic [ROB_WIDTH-1:0] query2Index,
    output logic                 query2Ready,
    output logic [31:0]          query2Val,
    output logic                 commitValid,
    output logic [ROB_WIDTH-1:0] commitRobIndex,
    output logic [4:0]           commitRd,
    output logic [31:0]          commitVal,
    output logic                 storeCommit,
    output logic                 clearOut,
    output logic [31:0]          newPcOut
);
    localparam int DEPTH = 1 << ROB_WIDTH;

    logic [DEPTH-1:0]     valid;
    logic [DEPTH-1:0]     done;
    logic [DEPTH-1:0]     pred;
    logic [1:0]           kind   [DEPTH];
    logic [4:0]           rd     [DEPTH];
    logic [31:0]          alt_pc [DEPTH];
    logic [31:0]          value  [DEPTH];
    logic [ROB_WIDTH-1:0] head;
    logic [ROB_WIDTH-1:0] tail;
    logic [ROB_WIDTH:0]   count;
    logic                 retire;
    logic                 is_store;
    logic                 is_branch;
    logic                 is_reg;
    logic                 flush;
    logic                 issue_ok;

    assign issueRobIndex = tail;
    assign full          = count >= (ROB_WIDTH+1)'(DEPTH - 1);
    assign query1Ready   = valid[query1Index] && done[query1Index];
    assign query1Val     = value[query1Index];
    assign query2Ready   = valid[query2Index] && done[query2Index];
    assign query2Val     = value[query2Index];

    // type 3 is reserved and retires exactly like a register writeback
    always_comb begin
        retire    = readyIn && valid[head] && done[head];
        is_store  = kind[head] == 2'd1;
        is_branch = kind[head] == 2'd2;
        is_reg    = !is_store && !is_branch;
        flush     = retire && is_branch && (value[head][0] != pred[head]);
        issue_ok  = readyIn && issueValid && !full && !flush;
    end

    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            valid          <= '0;
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            commitValid    <= 1'b0;
            storeCommit    <= 1'b0;
            clearOut       <= 1'b0;
            commitRobIndex <= '0;
            commitRd       <= '0;
            commitVal      <= '0;
            newPcOut       <= '0;
        end else if (readyIn) begin
            commitValid <= retire && is_reg;
            storeCommit <= retire && is_store;
            clearOut    <= flush;
            if (retire)
                commitRobIndex <= head;
            if (retire && is_reg) begin
                commitRd  <= rd[head];
                commitVal <= value[head];
            end
            if (flush) begin
                newPcOut <= alt_pc[head];
                valid    <= '0;
                head     <= '0;
                tail     <= '0;
                count    <= '0;
            end else begin
                if (retire) begin
                    valid[head] <= 1'b0;
                    head        <= head + 1'b1;
                end
                if (issue_ok) begin
                    valid[tail] <= 1'b1;
                    tail        <= tail + 1'b1;
                end
                count <= count + (ROB_WIDTH+1)'(issue_ok) - (ROB_WIDTH+1)'(retire);
            end
        end
    end

    // payload carries no reset: it is only observed through valid
    always_ff @(posedge clockIn) begin
        if (readyIn) begin
            if (rsUpdate && valid[rsRobIndex]) begin
                value[rsRobIndex] <= rsUpdateVal;
                done[rsRobIndex]  <= 1'b1;
            end
            if (lsbUpdate && valid[lsbRobIndex]) begin
                value[lsbRobIndex] <= lsbUpdateVal;
                done[lsbRobIndex]  <= 1'b1;
            end
            if (issue_ok) begin
                kind[tail]   <= issueType;
                rd[tail]     <= issueRd;
                pred[tail]   <= issuePredTaken;
                alt_pc[tail] <= issueAltPc;
                done[tail]   <= issueType == 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed stimulus with a retirement scoreboard; a monitor pops
// expected retirements whenever the buffer pulses commit/store/clear.
module tb_reorder_buffer;
    typedef struct packed {
        logic [1:0]  kind;
        logic [3:0]  idx;
        logic [4:0]  rd;
        logic [31:0] val;
    } exp_t;

    logic        clockIn = 1'b0;
    logic        resetIn = 1'b0;
    logic        readyIn = 1'b1;
    logic        issueValid = 1'b0;
    logic [1:0]  issueType = '0;
    logic [4:0]  issueRd = '0;
    logic        issuePredTaken = 1'b0;
    logic [31:0] issueAltPc = '0;
    logic [3:0]  issueRobIndex;
    logic        full;
    logic        rsUpdate = 1'b0;
    logic [3:0]  rsRobIndex = '0;
    logic [31:0] rsUpdateVal = '0;
    logic        lsbUpdate = 1'b0;
    logic [3:0]  lsbRobIndex = '0;
    logic [31:0] lsbUpdateVal = '0;
    logic [3:0]  query1Index = '0;
    logic        query1Ready;
    logic [31:0] query1Val;
    logic [3:0]  query2Index = '0;
    logic        query2Ready;
    logic [31:0] query2Val;
    logic        commitValid;
    logic [3:0]  commitRobIndex;
    logic [4:0]  commitRd;
    logic [31:0] commitVal;
    logic        storeCommit;
    logic        clearOut;
    logic [31:0] newPcOut;

    int   compared = 0;
    int   mismatched = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic mon_rdy;
    logic mon_rst;

    reorder_buffer #(.ROB_WIDTH(4)) dut (
        .clockIn(clockIn), .resetIn(resetIn), .readyIn(readyIn),
        .issueValid(issueValid), .issueType(issueType), .issueRd(issueRd),
        .issuePredTaken(issuePredTaken), .issueAltPc(issueAltPc),
        .issueRobIndex(issueRobIndex), .full(full),
        .rsUpdate(rsUpdate), .rsRobIndex(rsRobIndex), .rsUpdateVal(rsUpdateVal),
        .lsbUpdate(lsbUpdate), .lsbRobIndex(lsbRobIndex), .lsbUpdateVal(lsbUpdateVal),
        .query1Index(query1Index), .query1Ready(query1Ready), .query1Val(query1Val),
        .query2Index(query2Index), .query2Ready(query2Ready), .query2Val(query2Val),
        .commitValid(commitValid), .commitRobIndex(commitRobIndex), .commitRd(commitRd),
        .commitVal(commitVal), .storeCommit(storeCommit), .clearOut(clearOut),
        .newPcOut(newPcOut)
    );

    always #5 clockIn = ~clockIn;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clockIn);
    endtask

    task automatic reset_pulse();
        resetIn = 1'b0;
        tick();
        resetIn = 1'b1;
    endtask

    task automatic issue(input logic [1:0] t, input logic [4:0] r, input logic p, input logic [31:0] pc);
        issueValid = 1'b1;
        issueType = t;
        issueRd = r;
        issuePredTaken = p;
        issueAltPc = pc;
        tick();
        issueValid = 1'b0;
    endtask

    task automatic rs(input logic [3:0] tag, input logic [31:0] v);
        rsUpdate = 1'b1;
        rsRobIndex = tag;
        rsUpdateVal = v;
        tick();
        rsUpdate = 1'b0;
    endtask

    // monitor: outputs registered at an enabled edge are compared 1 time unit later
    always @(posedge clockIn) begin
        mon_rdy = readyIn;
        mon_rst = resetIn;
        #1;
        if (mon_rdy && mon_rst && (commitValid || storeCommit || clearOut)) begin
            if (exp_q.size() == 0)
                check("unexpected_retire", {29'b0, clearOut, storeCommit, commitValid}, 0);
            else begin
                mon_e = exp_q.pop_front();
                check("retire_kind", {29'b0, clearOut, storeCommit, commitValid}, 32'(1) << mon_e.kind);
                if (mon_e.kind == 2'd0) begin
                    check("commit_idx", 32'(commitRobIndex), 32'(mon_e.idx));
                    check("commit_rd", 32'(commitRd), 32'(mon_e.rd));
                    check("commit_val", commitVal, mon_e.val);
                end else if (mon_e.kind == 2'd1)
                    check("store_idx", 32'(commitRobIndex), 32'(mon_e.idx));
                else
                    check("new_pc", newPcOut, mon_e.val);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        tick();
        tick();
        resetIn = 1'b1;
        check("rst_commit_valid", 32'(commitValid), 0);
        check("rst_store_commit", 32'(storeCommit), 0);
        check("rst_clear", 32'(clearOut), 0);
        check("rst_commit_val", commitVal, 0);
        check("rst_new_pc", newPcOut, 0);
        check("rst_tail", 32'(issueRobIndex), 0);
        check("rst_full", 32'(full), 0);

        // single REG round trip
        issue(2'd0, 5'd5, 1'b0, 0);
        check("t1_tail", 32'(issueRobIndex), 1);
        exp_q.push_back('{2'd0, 4'd0, 5'd5, 32'h1234});
        rs(4'd0, 32'h1234);
        tick();
        check("t1_count", 32'(dut.count), 0);

        // fill to 15, full, dropped issue, wrap
        reset_pulse();
        for (int i = 0; i < 15; i++) issue(2'd0, 5'(i), 1'b0, 0);
        check("t2_full", 32'(full), 1);
        check("t2_tail15", 32'(issueRobIndex), 15);
        issue(2'd0, 5'd31, 1'b0, 0);
        check("t2_drop_tail", 32'(issueRobIndex), 15);
        check("t2_drop_count", 32'(dut.count), 15);
        exp_q.push_back('{2'd0, 4'd0, 5'd0, 32'hA0});
        rs(4'd0, 32'hA0);
        check("t2_full_after_update", 32'(full), 1);
        tick();
        check("t2_full_after_commit", 32'(full), 0);
        issue(2'd0, 5'd15, 1'b0, 0);
        check("t2_tail_wrap", 32'(issueRobIndex), 0);
        check("t2_full_again", 32'(full), 1);

        // out-of-order completion, in-order commit
        reset_pulse();
        issue(2'd0, 5'd1, 1'b0, 0);
        issue(2'd0, 5'd2, 1'b0, 0);
        rs(4'd1, 32'hB);
        exp_q.push_back('{2'd0, 4'd0, 5'd1, 32'hA});
        exp_q.push_back('{2'd0, 4'd1, 5'd2, 32'hB});
        rs(4'd0, 32'hA);
        tick();
        check("t3_first_idx", 32'(commitRobIndex), 0);
        tick();
        check("t3_second_valid", 32'(commitValid), 1);
        check("t3_second_idx", 32'(commitRobIndex), 1);
        tick();
        check("t3_idle_valid", 32'(commitValid), 0);

        // mispredict flush discards same-cycle issue and update
        reset_pulse();
        issue(2'd2, 5'd0, 1'b0, 32'h100);
        issue(2'd0, 5'd3, 1'b0, 0);
        issue(2'd0, 5'd4, 1'b0, 0);
        query1Index = 4'd1;
        query2Index = 4'd2;
        rs(4'd1, 32'h77);
        check("t4_q1_ready_pre", 32'(query1Ready), 1);
        check("t4_q1_val_pre", query1Val, 32'h77);
        exp_q.push_back('{2'd2, 4'd0, 5'd0, 32'h100});
        rs(4'd0, 32'd1);
        issueValid = 1'b1;
        issueType = 2'd0;
        issueRd = 5'd6;
        rsUpdate = 1'b1;
        rsRobIndex = 4'd2;
        rsUpdateVal = 32'h55;
        tick();
        issueValid = 1'b0;
        rsUpdate = 1'b0;
        check("t4_clear", 32'(clearOut), 1);
        check("t4_new_pc", newPcOut, 32'h100);
        check("t4_q1_flushed", 32'(query1Ready), 0);
        check("t4_q2_flushed", 32'(query2Ready), 0);
        check("t4_tail_zero", 32'(issueRobIndex), 0);
        tick();
        check("t4_clear_pulse", 32'(clearOut), 0);
        issue(2'd2, 5'd0, 1'b1, 32'h200);
        rs(4'd0, 32'd1);
        tick();
        check("t4_ok_branch_tail", 32'(issueRobIndex), 1);
        check("t4_ok_branch_count", 32'(dut.count), 0);
        check("t4_ok_branch_clear", 32'(clearOut), 0);

        // store retires one edge after allocation, concurrent issue
        reset_pulse();
        issue(2'd1, 5'd0, 1'b0, 0);
        exp_q.push_back('{2'd1, 4'd0, 5'd0, 32'd0});
        issue(2'd0, 5'd9, 1'b0, 0);
        check("t5_store", 32'(storeCommit), 1);
        check("t5_store_idx", 32'(commitRobIndex), 0);
        check("t5_count", 32'(dut.count), 1);
        check("t5_tail", 32'(issueRobIndex), 2);
        tick();
        check("t5_store_pulse", 32'(storeCommit), 0);

        // dual update, query visibility, readyIn hold
        issue(2'd0, 5'd10, 1'b0, 0);
        issue(2'd0, 5'd11, 1'b0, 0);
        query1Index = 4'd2;
        query2Index = 4'd3;
        rsUpdate = 1'b1;
        rsRobIndex = 4'd2;
        rsUpdateVal = 32'h22;
        lsbUpdate = 1'b1;
        lsbRobIndex = 4'd3;
        lsbUpdateVal = 32'h33;
        #1;
        check("t6_q1_no_bypass", 32'(query1Ready), 0);
        tick();
        rsUpdate = 1'b0;
        lsbUpdate = 1'b0;
        check("t6_q1_ready", 32'(query1Ready), 1);
        check("t6_q1_val", query1Val, 32'h22);
        check("t6_q2_ready", 32'(query2Ready), 1);
        check("t6_q2_val", query2Val, 32'h33);
        readyIn = 1'b0;
        issueValid = 1'b1;
        issueType = 2'd0;
        issueRd = 5'd12;
        rsUpdate = 1'b1;
        rsRobIndex = 4'd1;
        rsUpdateVal = 32'h99;
        query1Index = 4'd1;
        repeat (3) tick();
        issueValid = 1'b0;
        rsUpdate = 1'b0;
        check("t6_hold_tail", 32'(issueRobIndex), 4);
        check("t6_hold_count", 32'(dut.count), 3);
        check("t6_hold_q1", 32'(query1Ready), 0);
        readyIn = 1'b1;
        exp_q.push_back('{2'd0, 4'd1, 5'd9, 32'h11});
        exp_q.push_back('{2'd0, 4'd2, 5'd10, 32'h22});
        exp_q.push_back('{2'd0, 4'd3, 5'd11, 32'h33});
        lsbUpdate = 1'b1;
        lsbRobIndex = 4'd1;
        lsbUpdateVal = 32'h11;
        tick();
        lsbUpdate = 1'b0;
        repeat (3) tick();
        check("t6_drained", 32'(dut.count), 0);

        // asynchronous reset mid-stream
        issue(2'd1, 5'd0, 1'b0, 0);
        exp_q.push_back('{2'd1, 4'd4, 5'd0, 32'd0});
        issue(2'd0, 5'd13, 1'b0, 0);
        check("t7_store_pre", 32'(storeCommit), 1);
        #2;
        resetIn = 1'b0;
        #1;
        check("t7_store", 32'(storeCommit), 0);
        check("t7_idx", 32'(commitRobIndex), 0);
        check("t7_val", commitVal, 0);
        check("t7_tail", 32'(issueRobIndex), 0);
        check("t7_count", 32'(dut.count), 0);
        tick();
        resetIn = 1'b1;
        tick();
        check("pending_expected", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order retirement buffer that sits directly downstream of the reservation station and the load/store buffer.
- The instruction unit allocates one entry per issued instruction; the entry index is the ROB tag used as the dependency constraint everywhere else.
- Entries are completed by result broadcasts from the reservation station (ALU/branch) and the load/store buffer.
- Entries retire one per cycle in program order: register writeback, store release, or branch resolution with full flush on mispredict.

Parameters:
- ROB_WIDTH, 4, log2 of entry count (16 entries); tag width.

Ports:
- clockIn  in  1  clock, rising-edge.
- resetIn  in  1  asynchronous active-low reset.
- readyIn  in  1  global enable; when 0 all state holds.
- issueValid  in  1  allocate entry this cycle.
- issueType  in  2  0=REG writeback, 1=STORE, 2=BRANCH, 3=reserved (treated as REG).
- issueRd  in  5  destination register (REG only).
- issuePredTaken  in  1  predicted direction (BRANCH only).
- issueAltPc  in  32  PC to redirect to on mispredict (BRANCH only).
- issueRobIndex  out  ROB_WIDTH  tag the next allocation receives (= tail).
- full  out  1  no allocation permitted.
- rsUpdate  in  1  reservation station result valid.
- rsRobIndex  in  ROB_WIDTH  reservation station result tag.
- rsUpdateVal  in  32  reservation station result.
- lsbUpdate  in  1  load result valid.
- lsbRobIndex  in  ROB_WIDTH  load result tag.
- lsbUpdateVal  in  32  load result.
- query1Index  in  ROB_WIDTH  operand lookup tag, port 1.
- query1Ready  out  1  port 1 entry valid and complete.
- query1Val  out  32  port 1 entry value.
- query2Index  in  ROB_WIDTH  operand lookup tag, port 2.
- query2Ready  out  1  port 2 entry valid and complete.
- query2Val  out  32  port 2 entry value.
- commitValid  out  1  REG entry retired this cycle.
- commitRobIndex  out  ROB_WIDTH  tag of retired entry.
- commitRd  out  5  destination register of retired entry.
- commitVal  out  32  value of retired entry.
- storeCommit  out  1  store at commitRobIndex may perform.
- clearOut  out  1  mispredict flush pulse.
- newPcOut  out  32  redirect PC, valid with clearOut.

Behaviour:
- Storage: per entry valid, ready, type, rd, predTaken, altPc, value; head and tail pointers of ROB_WIDTH bits; count of ROB_WIDTH+1 bits. Pointers wrap modulo 2**ROB_WIDTH.
- Reset (resetIn low, asynchronous):
  - All entries invalid; head=tail=count=0.
  - commitValid, storeCommit and clearOut are 0; commitRobIndex, commitRd, commitVal and newPcOut are 0.
- full = (count >= 2**ROB_WIDTH-1). This leaves one slot of slack because the issue stage registers its request.
- Allocation: on readyIn && issueValid, write the entry at tail with valid=1, tail+1.
  - STORE entries are written with ready=1.
  - REG and BRANCH entries are written with ready=0.
  - issueValid while full is a protocol violation and the entry is dropped.
- Completion:
  - On rsUpdate, the entry at rsRobIndex is written value=rsUpdateVal, ready=1, only if that entry is valid.
  - On lsbUpdate, the same rule applies for the entry at lsbRobIndex.
  - Both updates in the same cycle to distinct tags are both applied. The same tag from both sources is a protocol violation; the lsb value wins.
- Query ports are combinational with no bypass.
  - queryNReady = valid[idx] && ready[idx]; queryNVal = value[idx].
  - An update in the same cycle is visible only on the next cycle.
- Retirement: at most one per cycle, when the head entry is valid and ready (registered flags).
  - REG: commitValid=1, with commitRobIndex, commitRd and commitVal from the entry. rd=0 is still reported; the register file ignores x0.
  - STORE: storeCommit=1 and commitRobIndex=head.
  - BRANCH, correct prediction (value[0]==predTaken): the entry is retired with no pulse.
  - BRANCH, mispredict: clearOut=1 and newPcOut=altPc.
  - After any retirement, head+1 and the entry is invalidated.
- All retirement outputs are registered and valid the cycle after the decision. Pulses last exactly one cycle and are forced to 0 on any cycle with readyIn high and no retirement.
- Flush: in the same edge that registers clearOut=1, all entries are invalidated and head=tail=count=0.
  - Any issue or update presented in that cycle is discarded.
  - The next cycle accepts issue at tag 0.
- count update: count_next = count + issue_accepted - retired. Simultaneous issue and retire leaves count unchanged.
- Latency:
  - An update at edge N makes the entry ready after N.
  - If that entry is at head, it retires at edge N+1, and outputs are visible after N+1.
  - Minimum latency from issue to retire for a STORE is 1 edge after allocation.
- readyIn low: pointers, entries and count hold. Pulse outputs hold their last value; the consumer gates them with readyIn.
- Reset mid-operation clears everything asynchronously regardless of readyIn.

Test Plan:
- Reset then issue REG rd=5; rsUpdate tag 0 val 0x1234 -> next edge commitValid=1, commitRobIndex=0, commitRd=5, commitVal=0x1234; count returns to 0.
- Issue 15 REG entries without updates -> full=1 at count=15, issueRobIndex=15.
  - Then complete tag 0 -> full deasserts one edge after commit.
  - Tail wraps to 0 after the 16th allocation.
- Issue REG (tag 0), REG (tag 1); complete tag 1 first with 0xB then tag 0 with 0xA -> commits occur in order: tag 0/0xA, then tag 1/0xB on consecutive cycles.
- Issue BRANCH predTaken=0 altPc=0x100, then two REGs; rsUpdate tag 0 val 1 -> clearOut=1, newPcOut=0x100 for one cycle; query on tags 1 and 2 returns ready=0; next issue gets tag 0.
- Issue STORE at an empty ROB -> storeCommit=1 with commitRobIndex=0 one edge after allocation; issue REG in the same cycle as that retirement -> count stays 1.
- Same-cycle rsUpdate tag 2 (0x22) and lsbUpdate tag 3 (0x33) -> query1Index=2 returns 0x22 ready, query2Index=3 returns 0x33 ready; hold readyIn=0 for 3 cycles -> no state change. Assert resetIn low mid-stream -> immediate empty buffer with outputs 0.
